// File: rtl/number_frame_tx.sv
// number_frame_tx: serialises a latched 9-digit BCD number as an ASCII frame
// on a valid/ready byte stream.
//   short frame : SEP d0 d1 d2 d3 d4 d5 d6 d7 d8 END            (11 bytes)
//   long frame  : SEP d0 d1 d2 SEP d3 d4 d5 SEP d6 d7 d8 END    (13 bytes)
//
// Handshake: a byte transfers on a rising edge where valid && ready. data_out
// and valid are registered and hold while valid=1 and ready=0; ready has no
// effect while valid=0. start is only looked at in IDLE (busy=0).
module number_frame_tx #(
    parameter logic [7:0] SEP_CHAR = 8'h20,
    parameter logic [7:0] END_CHAR = 8'h0A,
    parameter logic [7:0] BAD_CHAR = 8'h3F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        long_fmt,
    input  logic [35:0] digits,
    input  logic        ready,
    output logic [7:0]  data_out,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic        bad_digit,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_DIGIT = 3'd2,
        S_SEP   = 3'd3,
        S_TRAIL = 3'd4
    } state_t;

    state_t      state;
    logic [3:0]  index;      // digit currently on data_out while in S_DIGIT
    logic [35:0] digit_sr;   // remaining digits, next one to send in [35:32]
    logic        fmt_long;   // latched format select
    logic        any_bad;    // some digit on the input bus exceeds 9
    logic        xfer;

    assign xfer      = valid && ready;
    assign fsm_state = state;

    // ASCII code for one BCD digit; out-of-range nibbles become BAD_CHAR.
    function automatic logic [7:0] encode(input logic [3:0] v);
        if (v <= 4'd9) begin
            return 8'h30 + {4'h0, v};
        end
        return BAD_CHAR;
    endfunction

    // Scan all nine incoming digits so bad_digit is known at accept time.
    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (digits[4*i +: 4] > 4'd9) begin
                any_bad = 1'b1;
            end
        end
    end

    // Frame sequencer: state, digit index, latched inputs and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            index     <= 4'd0;
            digit_sr  <= 36'd0;
            fmt_long  <= 1'b0;
            data_out  <= 8'h00;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bad_digit <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !busy) begin
                        state     <= S_LEAD;
                        index     <= 4'd0;
                        digit_sr  <= digits;
                        fmt_long  <= long_fmt;
                        bad_digit <= any_bad;
                        data_out  <= SEP_CHAR;
                        valid     <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_LEAD: begin
                    if (xfer) begin
                        state    <= S_DIGIT;
                        data_out <= encode(digit_sr[35:32]);
                        digit_sr <= {digit_sr[31:0], 4'h0};
                    end
                end
                S_DIGIT: begin
                    if (xfer) begin
                        if (index == 4'd8) begin
                            state    <= S_TRAIL;
                            data_out <= END_CHAR;
                        end else if (fmt_long && (index == 4'd2 || index == 4'd5)) begin
                            state    <= S_SEP;
                            data_out <= SEP_CHAR;
                        end else begin
                            index    <= index + 4'd1;
                            data_out <= encode(digit_sr[35:32]);
                            digit_sr <= {digit_sr[31:0], 4'h0};
                        end
                    end
                end
                S_SEP: begin
                    if (xfer) begin
                        state    <= S_DIGIT;
                        index    <= index + 4'd1;
                        data_out <= encode(digit_sr[35:32]);
                        digit_sr <= {digit_sr[31:0], 4'h0};
                    end
                end
                S_TRAIL: begin
                    if (xfer) begin
                        state    <= S_IDLE;
                        data_out <= 8'h00;
                        valid    <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_number_frame_tx.sv
// Bench for number_frame_tx: randomised and directed frames checked against a
// byte-list reference model built directly from the frame layout rules.
module tb_number_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        long_fmt = 1'b0;
    logic [35:0] digits = 36'd0;
    logic        ready = 1'b0;
    logic [7:0]  data_out;
    logic        valid;
    logic        busy;
    logic        done;
    logic        bad_digit;
    logic [2:0]  fsm_state;

    int compared = 0;
    int mismatched = 0;

    // expected / observed frames
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic       exp_bad;

    // per-frame observations collected by drive_frame
    int cyc, unstable, bad_ones, bad_zeros, busy_lo;
    bit timed_out;

    number_frame_tx dut (
        .clk(clk), .rst(rst), .start(start), .long_fmt(long_fmt),
        .digits(digits), .ready(ready), .data_out(data_out), .valid(valid),
        .busy(busy), .done(done), .bad_digit(bad_digit), .fsm_state(fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    // reference model: frame bytes from the layout rules
    task automatic ref_frame(input logic [35:0] d, input logic lf);
        logic [3:0] v;
        exp_q.delete();
        exp_bad = 1'b0;
        exp_q.push_back(8'h20);
        for (int i = 0; i < 9; i++) begin
            if (lf && (i == 3 || i == 6)) exp_q.push_back(8'h20);
            v = 4'((d >> (4 * (8 - i))) & 36'hF);
            if (v <= 9) exp_q.push_back(8'h30 + 8'(v));
            else begin
                exp_q.push_back(8'h3F);
                exp_bad = 1'b1;
            end
        end
        exp_q.push_back(8'h0A);
    endtask

    // driver: request a frame at the current negedge, leave at the next negedge
    task automatic start_frame(input logic [35:0] d, input logic lf);
        start = 1'b1;
        digits = d;
        long_fmt = lf;
        @(negedge clk);
        start = 1'b0;
    endtask

    // driver: apply ready pattern and collect transferred bytes until done.
    // mode 0: ready=1, 1: ready pattern 1,0,0, 2: random ready.
    // inject_at >= 0 pulses a competing start once that many bytes transferred.
    task automatic drive_frame(input int mode, input int inject_at);
        bit held;
        logic [7:0] held_byte;
        bit r;
        bit injected;
        obs_q.delete();
        cyc = 0; unstable = 0; bad_ones = 0; bad_zeros = 0; busy_lo = 0;
        timed_out = 1'b1;
        held = 1'b0;
        held_byte = 8'h00;
        injected = 1'b0;
        for (int c = 0; c < 300; c++) begin
            start = 1'b0;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            cyc++;
            if (held && (!valid || data_out !== held_byte)) unstable++;
            if (!busy) busy_lo++;
            case (mode)
                0: r = 1'b1;
                1: r = (c % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            ready = r;
            if (!injected && inject_at >= 0 && obs_q.size() == inject_at) begin
                injected = 1'b1;
                start = 1'b1;
                digits = 36'h999999999;
                long_fmt = ~long_fmt;
            end
            if (valid) begin
                if (bad_digit) bad_ones++; else bad_zeros++;
                if (r) begin
                    obs_q.push_back(data_out);
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_byte = data_out;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        compared++;
        if ({data_out, valid, busy, done, bad_digit, fsm_state} !== 15'd0) begin
            mismatched++;
            $display("FAIL reset_values: got data=%h v=%b b=%b d=%b bad=%b st=%0d, want all zero",
                     data_out, valid, busy, done, bad_digit, fsm_state);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_short;
        ref_frame(36'h123456789, 1'b0);
        start_frame(36'h123456789, 1'b0);
        compared++;
        if (valid !== 1'b1 || busy !== 1'b1 || data_out !== 8'h20) begin
            mismatched++;
            $display("FAIL short_first: got v=%b b=%b data=%h, want 1 1 20", valid, busy, data_out);
        end
        drive_frame(0, -1);
        compared++;
        if (timed_out || obs_q.size() != exp_q.size() || cyc != 11) begin
            mismatched++;
            $display("FAIL short_len: got bytes=%0d cycles=%0d timeout=%0b, want 11 11 0",
                     obs_q.size(), cyc, timed_out);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            compared++;
            if (obs_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL short_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        compared++;
        if (valid !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00 || busy_lo != 0) begin
            mismatched++;
            $display("FAIL short_done_cycle: got v=%b b=%b data=%h busy_lo=%0d, want 0 0 00 0",
                     valid, busy, data_out, busy_lo);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("FAIL short_done_width: got done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_long;
        ref_frame(36'h123456789, 1'b1);
        start_frame(36'h123456789, 1'b1);
        drive_frame(0, -1);
        compared++;
        if (timed_out || obs_q.size() != exp_q.size() || cyc != 13) begin
            mismatched++;
            $display("FAIL long_len: got bytes=%0d cycles=%0d timeout=%0b, want 13 13 0",
                     obs_q.size(), cyc, timed_out);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            compared++;
            if (obs_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL long_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        ref_frame(36'h123456789, 1'b1);
        start_frame(36'h123456789, 1'b1);
        drive_frame(1, -1);
        compared++;
        if (timed_out || obs_q.size() != exp_q.size() || unstable != 0) begin
            mismatched++;
            $display("FAIL bp_frame: got bytes=%0d unstable=%0d timeout=%0b, want 13 0 0",
                     obs_q.size(), unstable, timed_out);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            compared++;
            if (obs_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL bp_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy;
        ref_frame(36'h123456789, 1'b1);
        start_frame(36'h123456789, 1'b1);
        drive_frame(0, 4);
        compared++;
        if (timed_out || obs_q.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL busy_start_len: got bytes=%0d timeout=%0b, want 13 0", obs_q.size(), timed_out);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            compared++;
            if (obs_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL busy_start_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            compared++;
            if (valid !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL busy_start_no_second: got v=%b b=%b, want 0 0", valid, busy);
            end
        end
        ready = 1'b0;
    endtask

    task automatic test_bad_digit;
        ref_frame(36'h12A45678F, 1'b0);
        start_frame(36'h12A45678F, 1'b0);
        drive_frame(0, -1);
        compared++;
        if (!exp_bad || bad_zeros != 0 || bad_ones != 11) begin
            mismatched++;
            $display("FAIL bad_flag: got ones=%0d zeros=%0d, want 11 0", bad_ones, bad_zeros);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            compared++;
            if (obs_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL bad_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        // a clean frame must clear the flag from its first byte
        @(negedge clk);
        ref_frame(36'h000111222, 1'b0);
        start_frame(36'h000111222, 1'b0);
        drive_frame(0, -1);
        compared++;
        if (exp_bad || bad_ones != 0 || obs_q.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL bad_clear: got ones=%0d bytes=%0d, want 0 11", bad_ones, obs_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        ref_frame(36'h555000555, 1'b0);
        start_frame(36'h555000555, 1'b0);
        drive_frame(0, -1);
        // start in the done cycle
        ref_frame(36'h987654321, 1'b1);
        start_frame(36'h987654321, 1'b1);
        compared++;
        if (done !== 1'b0 || valid !== 1'b1 || data_out !== 8'h20) begin
            mismatched++;
            $display("FAIL b2b_launch: got done=%b v=%b data=%h, want 0 1 20", done, valid, data_out);
        end
        drive_frame(0, -1);
        compared++;
        if (timed_out || obs_q.size() != exp_q.size() || cyc != 13) begin
            mismatched++;
            $display("FAIL b2b_len: got bytes=%0d cycles=%0d, want 13 13", obs_q.size(), cyc);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            compared++;
            if (obs_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL b2b_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        start_frame(36'h123456789, 1'b1);
        ready = 1'b1;
        repeat (5) @(negedge clk);
        ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        compared++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || data_out !== 8'h00 || fsm_state !== 3'd0) begin
            mismatched++;
            $display("FAIL mid_reset: got v=%b b=%b d=%b data=%h st=%0d, want 0 0 0 00 0",
                     valid, busy, done, data_out, fsm_state);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || valid !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset_quiet: got done=%b v=%b after release, want 0 0", done, valid);
        end
        ref_frame(36'h246802468, 1'b1);
        start_frame(36'h246802468, 1'b1);
        drive_frame(0, -1);
        compared++;
        if (timed_out || obs_q.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL mid_reset_fresh_len: got bytes=%0d, want 13", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            compared++;
            if (obs_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL mid_reset_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [35:0] d;
        logic lf;
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 9; k++)
                d[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
            lf = 1'($urandom_range(0, 1));
            ref_frame(d, lf);
            start_frame(d, lf);
            drive_frame(2, -1);
            compared++;
            if (timed_out || obs_q.size() != exp_q.size() || unstable != 0 ||
                (exp_bad ? bad_zeros != 0 : bad_ones != 0)) begin
                mismatched++;
                $display("FAIL rand[%0d]: got bytes=%0d unstable=%0d ones=%0d zeros=%0d, want %0d 0 bad=%b",
                         n, obs_q.size(), unstable, bad_ones, bad_zeros, exp_q.size(), exp_bad);
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                compared++;
                if (obs_q[i] !== exp_q[i]) begin
                    mismatched++;
                    $display("FAIL rand[%0d]_byte[%0d]: got %h want %h", n, i, obs_q[i], exp_q[i]);
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_backpressure();
        test_start_while_busy();
        test_bad_digit();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/number_frame_tx.md
# number_frame_tx

Transmit side of the number-sniffing byte stream. The block takes a 9-digit BCD number and a format select and serialises it as an ASCII frame, one byte per transfer, on a valid/ready byte interface. The frame is shaped so that the detector side flags it: the short format matches the 9-consecutive-digit pattern and the long format matches the "ddd ddd ddd" pattern. It feeds the sniffer datapath in loopback/self-test builds, and acts as the stimulus source for the detector in system benches.

## Interface
Parameters:
- SEP_CHAR, 8'h20, separator byte: leading byte and long-format group separator (ASCII space).
- END_CHAR, 8'h0A, trailing byte (ASCII LF).
- BAD_CHAR, 8'h3F, byte emitted in place of an invalid BCD digit (ASCII '?').

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a frame; sampled only when busy=0.
- long_fmt  in  1  0 = short frame, 1 = long frame; latched on start accept.
- digits  in  36  nine BCD digits; [35:32] is sent first and [3:0] last; latched on start accept.
- ready  in  1  downstream accepts data_out this cycle (maps to detector en).
- data_out  out  8  current frame byte; stable while valid=1 and ready=0.
- valid  out  1  data_out holds a frame byte.
- busy  out  1  a frame is in progress (accepted, trailer not yet transferred).
- done  out  1  one-cycle pulse after the trailer byte transfers.
- bad_digit  out  1  latched frame contained ≥1 digit >9; cleared on the next start accept.

## Operation
- Reset values: data_out=8'h00, valid=0, busy=0, done=0, bad_digit=0, state=IDLE, digit index=0.
- Frame contents:
  - short: SEP, d0..d8, END (11 bytes).
  - long: SEP, d0 d1 d2, SEP, d3 d4 d5, SEP, d6 d7 d8, END (13 bytes).
- Digit encoding: digit v in 0..9 is sent as 8'h30+v. v in 10..15 is sent as BAD_CHAR and sets bad_digit.
- bad_digit is computed over all nine latched digits at start accept, so it is valid from the first byte onward.
- States:
  - IDLE → LEAD on start && !busy.
  - LEAD → DIGIT on transfer.
  - DIGIT → SEP on transfer when long_fmt && index ∈ {2,5}.
  - DIGIT → TRAIL on transfer when index = 8.
  - DIGIT → DIGIT otherwise, with index+1.
  - SEP → DIGIT on transfer, with index+1.
  - TRAIL → IDLE on transfer.
- Transfer = valid && ready at the rising edge. A state or byte never advances without a transfer.
- index is a 4-bit counter 0..8. It resets to 0 on start accept and never wraps within a frame.
- start while busy=1 is ignored: no latch, no error, and the frame in flight is unaffected.
- Latched digits/long_fmt are immune to input changes after accept.
- ready is ignored while valid=0.
- Reset mid-frame: the frame is abandoned immediately (asynchronously) and all outputs return to reset values. No done pulse is produced.

## Timing
- Start accepted at edge N (start=1, busy=0 in the preceding cycle).
- After edge N: busy=1, valid=1, data_out=SEP.
- Each subsequent byte appears the cycle after the edge that transfers the previous byte.
- With ready held high, the whole frame spans 11 cycles (short) or 13 cycles (long).
- On the trailer transfer edge: valid=0, busy=0, done=1 for exactly one cycle, data_out returns to 8'h00.
- A start in the done cycle is accepted; back-to-back frames therefore have a 1-cycle gap.
- Backpressure: while ready=0, data_out, valid and state hold indefinitely.
- Outputs are registered; there is no combinational path from ready/start to data_out or valid.

## Test plan
- Short frame: digits=36'h123456789, long_fmt=0, ready=1. Expect bytes 20 31 32 33 34 35 36 37 38 39 0A on 11 consecutive cycles, then done=1 for 1 cycle and busy=0.
- Long frame: same digits, long_fmt=1. Expect 20 31 32 33 20 34 35 36 20 37 38 39 0A. Feeding this into the detector must produce long=1 exactly once.
- Backpressure: long frame with ready toggling 1,0,0,1,… Expect each byte held stable across ready=0 cycles, the same 13-byte sequence, and no byte dropped or duplicated.
- Start while busy: a second start with digits=36'h999999999 mid-frame. Expect the first frame to complete unchanged and no second frame. A start during the done cycle launches the next frame with SEP on the following cycle.
- Invalid digit: digits=36'h12A45678F, short. Expect 20 31 32 3F 34 35 36 37 38 3F 0A and bad_digit=1 from the first byte. The next valid start clears bad_digit.
- Reset mid-frame: assert rst after the 5th byte of a long frame. Expect valid=busy=done=0 and data_out=00 immediately. A fresh start after release emits a complete frame starting at SEP.
